// File: rtl/lc3_ea_ctrl_pkg.sv
// lc3_ea_ctrl_pkg: opcodes, FSM encodings and field widths for the LC-3 EA sequencer
package lc3_ea_ctrl_pkg;
  localparam logic [3:0] OP_BR = 4'h0, OP_ADD = 4'h1, OP_LD = 4'h2, OP_ST = 4'h3;
  localparam logic [3:0] OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7;
  localparam logic [3:0] OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC, OP_RES = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF;
  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_IND_REQ = 2'd2, S_OUT = 2'd3;
  localparam int W_OFF6 = 6, W_OFF9 = 9, W_OFF11 = 11;
  function automatic logic is_ind(input logic [3:0] op);
    return op == OP_LDI || op == OP_STI;
  endfunction
endpackage

// File: rtl/lc3_ea_ctrl_sext.sv
// sext: sign-extend a W-bit field to AW bits
module sext #(
  parameter int W  = 6,
  parameter int AW = 16
) (
  input  logic [W-1:0]  in_i,
  output logic [AW-1:0] out_o
);
  assign out_o = {{(AW-W){in_i[W-1]}}, in_i};
endmodule

// File: rtl/lc3_ea_ctrl.sv
// lc3_ea_ctrl: LC-3 effective-address sequencer; LC3_INDIRECT_EN builds the LDI/STI pointer read
module lc3_ea_ctrl
  import lc3_ea_ctrl_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ir_valid_i,
  output logic          ir_ready_o,
  input  logic [15:0]   ir_i,
  input  logic [AW-1:0] pc_i,
  output logic [2:0]    reg_sel_o,
  input  logic [AW-1:0] reg_data_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_ack_i,
  input  logic [AW-1:0] mem_rdata_i,
  output logic          ea_valid_o,
  input  logic          ea_ready_i,
  output logic [AW-1:0] ea_o,
  output logic          ea_err_o
);
  logic [1:0]    state_q, state_d;
  logic [15:0]   ir_q;
  logic [AW-1:0] pc_q, ea_q, ea_d, calc_ea, s6, s9, s11;
  logic          err_q, err_d, calc_err;
  logic [3:0]    op;
  assign op = ir_q[15:12];
  sext #(.W(W_OFF6),  .AW(AW)) u_sext6  (.in_i(ir_q[5:0]),  .out_o(s6));
  sext #(.W(W_OFF9),  .AW(AW)) u_sext9  (.in_i(ir_q[8:0]),  .out_o(s9));
  sext #(.W(W_OFF11), .AW(AW)) u_sext11 (.in_i(ir_q[10:0]), .out_o(s11));
  assign ir_ready_o = state_q == S_IDLE;
  assign reg_sel_o  = state_q == S_CALC ? ir_q[8:6] : 3'd0;
  assign ea_valid_o = state_q == S_OUT;
  assign ea_o       = ea_q;
  assign ea_err_o   = err_q;
`ifdef LC3_INDIRECT_EN
  assign mem_req_o  = state_q == S_IND_REQ;
  assign mem_addr_o = mem_req_o ? ea_q : '0;
`else
  logic unused_mem;
  assign unused_mem = ^{mem_ack_i, mem_rdata_i};
  assign mem_req_o  = 1'b0;
  assign mem_addr_o = '0;
`endif
  always_comb begin
    calc_ea  = '0;
    calc_err = 1'b0;
    case (op)
      OP_BR, OP_LD, OP_ST, OP_LEA: calc_ea = pc_q + s9;
      OP_LDI, OP_STI: begin
        calc_ea = pc_q + s9;
`ifndef LC3_INDIRECT_EN
        calc_err = 1'b1;
`endif
      end
      OP_JSR:         calc_ea = ir_q[11] ? pc_q + s11 : reg_data_i;
      OP_LDR, OP_STR: calc_ea = reg_data_i + s6;
      OP_JMP:         calc_ea = reg_data_i;
      OP_TRAP:        calc_ea = {{(AW-8){1'b0}}, ir_q[7:0]};
      default:        calc_err = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    ea_d    = ea_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: state_d = ir_valid_i ? S_CALC : S_IDLE;
      S_CALC: begin
        ea_d  = calc_ea;
        err_d = calc_err;
`ifdef LC3_INDIRECT_EN
        state_d = is_ind(op) ? S_IND_REQ : S_OUT;
`else
        state_d = S_OUT;
`endif
      end
`ifdef LC3_INDIRECT_EN
      S_IND_REQ: begin
        ea_d    = mem_ack_i ? mem_rdata_i : ea_q;
        state_d = mem_ack_i ? S_OUT : S_IND_REQ;
      end
`endif
      S_OUT:   state_d = ea_ready_i ? S_IDLE : S_OUT;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      pc_q    <= '0;
      ea_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ea_q    <= ea_d;
      err_q   <= err_d;
      if (ir_valid_i && ir_ready_o) begin
        ir_q <= ir_i;
        pc_q <= pc_i;
      end
    end
  end
endmodule
